// File: rtl/button_tap_decoder_pkg.sv
// Shared constants for the button front-end: clock rate, ms-to-cycles scale
// and the tap-decoder state encodings.
package button_tap_decoder_pkg;

  localparam int SYS_CLK_HZ    = 12_000_000;
  localparam int CYCLES_PER_MS = SYS_CLK_HZ / 1000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

endpackage

// File: rtl/button_tap_decoder_if.sv
// Press-pulse input and gesture-report outputs of the tap decoder.
interface button_tap_decoder_if #(
  parameter int CNT_W = 2
) ();

  logic             btn_tick;
  logic             tap_valid;
  logic [CNT_W-1:0] tap_count;
  logic             busy;

  modport master (output btn_tick, input tap_valid, tap_count, busy);
  modport slave  (input btn_tick, output tap_valid, tap_count, busy);

endinterface

// File: rtl/button_tap_decoder_gap_timer.sv
// Idle-gap up-counter: sync clear, enable, terminal flag at GAP_CYCLES-1.
module gap_timer #(
  parameter int TMR_W      = 22,
  parameter int GAP_CYCLES = 3_600_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign tc = (cnt == TMR_W'(GAP_CYCLES - 1));

endmodule

// File: rtl/button_tap_decoder.sv
// Groups debounced press pulses into gestures and reports the tap count
// once the gesture closes (idle gap elapsed or MAX_TAPS reached).
module button_tap_decoder
  import button_tap_decoder_pkg::*;
#(
  parameter int CLK_FREQ_HZ = SYS_CLK_HZ,
  parameter int GAP_CYCLES  = 300 * (CLK_FREQ_HZ / 1000),
  parameter int MAX_TAPS    = 3,
  parameter int CNT_W       = 2,
  parameter int TMR_W       = 22
) (
  input logic                clk,
  input logic                rst,
  button_tap_decoder_if.slave tap_if
);

  localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_TAPS);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] tap_count_q, tap_count_nxt;
  logic [CNT_W:0]   count_inc;
  logic             tap_valid_q, busy_q;
  logic             gap_clr, gap_en, gap_tc;

  // Timer restarts on every tick and sits at zero outside an open gesture.
  assign gap_clr = tap_if.btn_tick | (state != ST_COUNT);
  assign gap_en  = (state == ST_COUNT) & ~gap_tc;

  gap_timer #(
    .TMR_W      (TMR_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk (clk),
    .rst (rst),
    .clr (gap_clr),
    .en  (gap_en),
    .tc  (gap_tc)
  );

  assign count_inc = {1'b0, count} + (CNT_W + 1)'(1);

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    tap_count_nxt = tap_count_q;
    case (state)
      ST_IDLE: begin
        if (tap_if.btn_tick) begin
          state_nxt = ST_COUNT;
          count_nxt = CNT_W'(1);
        end
      end
      ST_COUNT: begin
        // A tick landing on the timeout cycle still extends the gesture.
        if (tap_if.btn_tick) begin
          count_nxt = count_inc[CNT_W-1:0];
          if (count_inc >= MAX_C) begin
            state_nxt     = ST_EMIT;
            tap_count_nxt = count_inc[CNT_W-1:0];
          end
        end else if (gap_tc) begin
          state_nxt     = ST_EMIT;
          tap_count_nxt = count;
        end
      end
      ST_EMIT: begin
        if (tap_if.btn_tick) begin
          state_nxt = ST_COUNT;
          count_nxt = CNT_W'(1);
        end else begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      tap_count_q <= '0;
      tap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      tap_count_q <= tap_count_nxt;
      tap_valid_q <= (state == ST_EMIT);
      busy_q      <= (state == ST_COUNT);
    end
  end

  assign tap_if.tap_valid = tap_valid_q;
  assign tap_if.tap_count = tap_count_q;
  assign tap_if.busy      = busy_q;

endmodule

// File: tb/tb_button_tap_decoder.sv
// Bench for button_tap_decoder with a short gap window (GAP_CYCLES=10).
module tb_button_tap_decoder;

  localparam int GAP   = 10;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_tap_decoder_if #(.CNT_W(CNT_W)) tif ();

  button_tap_decoder #(
    .CLK_FREQ_HZ (12_000_000),
    .GAP_CYCLES  (GAP),
    .MAX_TAPS    (3),
    .CNT_W       (CNT_W),
    .TMR_W       (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tap_if (tif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int cnt;
  } exp_t;

  typedef struct {
    string name;
    int    t0, t1, t2, t3;
    int    a0, c0, a1, c1;
    bit    chk_busy;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  bit mon_en = 1'b0;
  bit busy_chk = 1'b0;
  int busy_base = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_cnt, act, req);
    end
  endtask

  // Strobe monitor: every tap_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tif.tap_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe at edge %0d: got count %0d, expected no strobe",
                   edge_cnt, tif.tap_count);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_edge", edge_cnt, e.at);
          check("strobe_count", int'(tif.tap_count), e.cnt);
        end
      end
      if (busy_chk)
        check("busy", int'(tif.busy),
              ((edge_cnt >= busy_base + 1) && (edge_cnt <= busy_base + GAP)) ? 1 : 0);
    end
  end

  task automatic apply(input int t0, input int t1, input int t2, input int t3,
                       input int a0, input int c0, input int a1, input int c1,
                       input int rst_at, input int len, input bit chk_busy);
    int base;
    base = edge_cnt + 1;
    if (a0 >= 0) exp_q.push_back('{at: base + a0, cnt: c0});
    if (a1 >= 0) exp_q.push_back('{at: base + a1, cnt: c1});
    busy_base = base;
    busy_chk  = chk_busy;
    for (int c = 0; c < len; c++) begin
      tif.btn_tick = (c == t0) || (c == t1) || (c == t2) || (c == t3);
      rst = (c == rst_at);
      @(posedge clk);
      #1;
    end
    tif.btn_tick = 1'b0;
    rst = 1'b0;
    busy_chk = 1'b0;
  endtask

  task automatic check_drained(input string nm);
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"single",      0, -1, -1, -1, 11, 1, -1, 0, 1'b1};
    vecs[1] = '{"double",      0,  5, -1, -1, 16, 2, -1, 0, 1'b0};
    vecs[2] = '{"sat_emit",    0,  3,  6,  7,  7, 3, 18, 1, 1'b0};
    vecs[3] = '{"tick_on_tc",  0, 10, -1, -1, 21, 2, -1, 0, 1'b0};
    vecs[4] = '{"tick_after",  0, 11, -1, -1, 11, 1, 22, 1, 1'b0};
    vecs[5] = '{"burst_sat",   0,  1,  2, 12,  3, 3, 23, 1, 1'b0};
    vecs[6] = '{"gap_minus1",  0,  9, -1, -1, 20, 2, -1, 0, 1'b0};

    tif.btn_tick = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tap_valid", int'(tif.tap_valid), 0);
    check("reset_tap_count", int'(tif.tap_count), 0);
    check("reset_busy", int'(tif.busy), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3,
            vecs[i].a0, vecs[i].c0, vecs[i].a1, vecs[i].c1,
            -1, 30, vecs[i].chk_busy);
      check_drained({vecs[i].name, "_all_strobes"});
    end

    // Hold: count 2 must persist through a long idle stretch.
    apply(0, 5, -1, -1, 16, 2, -1, 0, -1, 20, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("hold_tap_count", int'(tif.tap_count), 2);
      check("hold_tap_valid", int'(tif.tap_valid), 0);
    end
    check_drained("hold_all_strobes");
    @(posedge clk);
    #1;

    // Reset mid-gesture, with a tick coinciding with reset.
    apply(0, 2, 4, -1, -1, 0, -1, 0, 4, 6, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("rst_tap_count", int'(tif.tap_count), 0);
      check("rst_busy", int'(tif.busy), 0);
    end
    check_drained("rst_no_strobe");

    // Gesture after reset still works normally.
    @(posedge clk);
    #1;
    apply(0, -1, -1, -1, 11, 1, -1, 0, -1, 16, 1'b0);
    check_drained("post_rst_single");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
